// File: rtl/frame_buffer.sv
// frame_buffer: indexed-color framebuffer with palette lookup,
// a three-stage scanout read path and a whole-frame clear engine.
module frame_buffer #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int COLOR_BITS     = 12
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [$clog2(RESOLUTION_X)-1:0]   fb_wr_x_i,
  input  logic [$clog2(RESOLUTION_Y)-1:0]   fb_wr_y_i,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_wr_index_i,
  input  logic                              fb_wr_en_i,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] palette_wr_index_i,
  input  logic [COLOR_BITS-1:0]             palette_wr_color_i,
  input  logic                              palette_wr_en_i,
  input  logic [$clog2(RESOLUTION_X)-1:0]   rd_x_i,
  input  logic [$clog2(RESOLUTION_Y)-1:0]   rd_y_i,
  input  logic                              rd_en_i,
  output logic [$clog2(PALETTE_LENGTH)-1:0] rd_index_o,
  output logic [COLOR_BITS-1:0]             rd_color_o,
  output logic                              rd_valid_o,
  input  logic                              clear_i,
  input  logic [$clog2(PALETTE_LENGTH)-1:0] clear_index_i,
  output logic                              busy_o,
  output logic [15:0]                       wr_drop_count_o
);

  localparam int XW = $clog2(RESOLUTION_X);
  localparam int YW = $clog2(RESOLUTION_Y);
  localparam int IW = $clog2(PALETTE_LENGTH);
  localparam int N  = RESOLUTION_X * RESOLUTION_Y;
  localparam int AW = $clog2(N);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  function automatic logic in_frame(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    return (32'(x) < RESOLUTION_X) &&
           (32'(y) < RESOLUTION_Y);
  endfunction

  function automatic logic [AW-1:0] lin_addr(
    input logic [XW-1:0] x,
    input logic [YW-1:0] y
  );
    return AW'(32'(y) * RESOLUTION_X + 32'(x));
  endfunction

  logic [IW-1:0]         fb_mem  [N];
  logic [COLOR_BITS-1:0] pal_mem [PALETTE_LENGTH];

  state_t        state;
  logic [AW-1:0] clr_addr;
  logic [IW-1:0] clr_index;

  logic          wr_in;
  logic          wr_blocked;
  logic          wr_take;
  logic          wr_drop;

  logic          w1_valid;
  logic [AW-1:0] w1_addr;
  logic [IW-1:0] w1_index;

  logic          r1_valid;
  logic          r1_in;
  logic [AW-1:0] r1_addr;
  logic          r2_valid;
  logic          r2_in;
  logic [IW-1:0] r2_index;

  // A clear accepted this cycle already owns the write port.
  assign wr_in      = in_frame(fb_wr_x_i, fb_wr_y_i);
  assign wr_blocked = (state == CLEAR) || clear_i;
  assign wr_take    = fb_wr_en_i && wr_in && !wr_blocked;
  assign wr_drop    = fb_wr_en_i && !(wr_in && !wr_blocked);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w1_valid <= 1'b0;
    end else begin
      w1_valid <= wr_take;
    end
    w1_addr  <= lin_addr(fb_wr_x_i, fb_wr_y_i);
    w1_index <= fb_wr_index_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_drop_count_o <= '0;
    end else if (wr_drop && wr_drop_count_o != 16'hFFFF) begin
      wr_drop_count_o <= wr_drop_count_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      clr_addr  <= '0;
      clr_index <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clear_i) begin
            state     <= CLEAR;
            busy_o    <= 1'b1;
            clr_addr  <= '0;
            clr_index <= clear_index_i;
          end
        end
        CLEAR: begin
          if (clr_addr == AW'(N - 1)) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Index memory: one write port, one read-first read port.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (state == CLEAR) begin
        fb_mem[clr_addr] <= clr_index;
      end else if (w1_valid) begin
        fb_mem[w1_addr] <= w1_index;
      end
    end
    if (r1_valid && r1_in) begin
      r2_index <= fb_mem[r1_addr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (palette_wr_en_i) begin
      pal_mem[palette_wr_index_i] <= palette_wr_color_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r1_valid <= 1'b0;
      r1_in    <= 1'b0;
      r2_valid <= 1'b0;
      r2_in    <= 1'b0;
    end else begin
      r1_valid <= rd_en_i;
      r1_in    <= in_frame(rd_x_i, rd_y_i);
      r2_valid <= r1_valid;
      r2_in    <= r1_in;
    end
    r1_addr <= lin_addr(rd_x_i, rd_y_i);
  end

  // Out-of-frame reads still complete, reporting index and color 0.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_valid_o <= 1'b0;
      rd_index_o <= '0;
      rd_color_o <= '0;
    end else begin
      rd_valid_o <= r2_valid;
      if (r2_valid) begin
        rd_index_o <= r2_in ? r2_index : '0;
        rd_color_o <= r2_in ? pal_mem[r2_index] : '0;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// tb_frame_buffer: randomized and directed stimulus against a
// pixel-level reference model, checked through a read scoreboard.
module tb_frame_buffer;

  localparam int RX = 40;
  localparam int RY = 30;
  localparam int PL = 256;
  localparam int CB = 12;
  localparam int XW = $clog2(RX);
  localparam int YW = $clog2(RY);
  localparam int IW = $clog2(PL);
  localparam int N  = RX * RY;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] wx = '0;
  logic [YW-1:0] wy = '0;
  logic [IW-1:0] widx = '0;
  logic          wen = 1'b0;
  logic [IW-1:0] pidx = '0;
  logic [CB-1:0] pcol = '0;
  logic          pen = 1'b0;
  logic [XW-1:0] rdx = '0;
  logic [YW-1:0] rdy = '0;
  logic          ren = 1'b0;
  logic [IW-1:0] rd_index;
  logic [CB-1:0] rd_color;
  logic          rd_valid;
  logic          clr = 1'b0;
  logic [IW-1:0] clr_index = '0;
  logic          busy;
  logic [15:0]   drops;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_buffer #(
    .RESOLUTION_X  (RX),
    .RESOLUTION_Y  (RY),
    .PALETTE_LENGTH(PL),
    .COLOR_BITS    (CB)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .fb_wr_x_i         (wx),
    .fb_wr_y_i         (wy),
    .fb_wr_index_i     (widx),
    .fb_wr_en_i        (wen),
    .palette_wr_index_i(pidx),
    .palette_wr_color_i(pcol),
    .palette_wr_en_i   (pen),
    .rd_x_i            (rdx),
    .rd_y_i            (rdy),
    .rd_en_i           (ren),
    .rd_index_o        (rd_index),
    .rd_color_o        (rd_color),
    .rd_valid_o        (rd_valid),
    .clear_i           (clr),
    .clear_index_i     (clr_index),
    .busy_o            (busy),
    .wr_drop_count_o   (drops)
  );

  typedef struct {
    int t;
    int x;
    int y;
    int idx;
    bit kidx;
    bit inr;
    int col;
    bit kcol;
  } rd_t;

  rd_t infl[$];
  rd_t sb[$];
  int  fb_m [N];
  bit  fb_k [N];
  int  pal_m [PL];
  bit  pal_k [PL];
  int  cyc = 0;
  int  clr_cnt = 0;
  int  clr_val = 0;
  int  drop_m = 0;

  // Reference model, advanced once per rising edge from the
  // sampled inputs: reads see frame state before this edge's
  // writes, palette state as of the edge the lookup happens.
  always @(posedge clk) begin
    bit  busy_b;
    bit  acc;
    bit  inr;
    int  a;
    rd_t e;
    if (reset) begin
      infl.delete();
      if (clr_cnt > 0) begin
        foreach (fb_k[i]) fb_k[i] = 1'b0;
      end
      clr_cnt = 0;
      drop_m  = 0;
    end else begin
      while (infl.size() > 0 && infl[0].t == cyc - 2) begin
        e = infl.pop_front();
        if (e.inr) begin
          e.col  = pal_m[e.idx];
          e.kcol = e.kidx && pal_k[e.idx];
        end else begin
          e.col  = 0;
          e.kcol = 1'b1;
        end
        sb.push_back(e);
      end
      if (ren) begin
        e.t   = cyc;
        e.x   = int'(rdx);
        e.y   = int'(rdy);
        e.inr = (e.x < RX) && (e.y < RY);
        if (e.inr) begin
          a      = e.y * RX + e.x;
          e.idx  = fb_m[a];
          e.kidx = fb_k[a];
        end else begin
          e.idx  = 0;
          e.kidx = 1'b1;
        end
        infl.push_back(e);
      end
      busy_b = clr_cnt > 0;
      acc    = !busy_b && clr;
      if (pen) begin
        pal_m[int'(pidx)] = int'(pcol);
        pal_k[int'(pidx)] = 1'b1;
      end
      if (wen) begin
        inr = (int'(wx) < RX) && (int'(wy) < RY);
        if (busy_b || acc || !inr) begin
          if (drop_m < 65535) drop_m++;
        end else begin
          a       = int'(wy) * RX + int'(wx);
          fb_m[a] = int'(widx);
          fb_k[a] = 1'b1;
        end
      end
      if (busy_b) begin
        if (clr_cnt < N) begin
          fb_m[clr_cnt] = clr_val;
          fb_k[clr_cnt] = 1'b1;
          clr_cnt++;
        end else begin
          clr_cnt = 0;
        end
      end else if (acc) begin
        clr_val = int'(clr_index);
        fb_m[0] = clr_val;
        fb_k[0] = 1'b1;
        clr_cnt = 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    rd_t e;
    checks++;
    if (busy !== (clr_cnt > 0)) begin
      errors++;
      $display("FAIL busy cyc=%0d got %0b want %0b",
               cyc, busy, clr_cnt > 0);
    end
    checks++;
    if (drops !== 16'(drop_m)) begin
      errors++;
      $display("FAIL drop_count cyc=%0d got %0d want %0d",
               cyc, drops, drop_m);
    end
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_valid cyc=%0d got 1 want 0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.kidx) begin
          checks++;
          if (rd_index !== IW'(e.idx)) begin
            errors++;
            $display("FAIL rd_index (%0d,%0d) got %0h want %0h",
                     e.x, e.y, rd_index, e.idx);
          end
        end
        if (e.kcol) begin
          checks++;
          if (rd_color !== CB'(e.col)) begin
            errors++;
            $display("FAIL rd_color (%0d,%0d) got %0h want %0h",
                     e.x, e.y, rd_color, e.col);
          end
        end
      end
    end else if (sb.size() > 0) begin
      checks++;
      errors++;
      e = sb.pop_front();
      $display("FAIL rd_valid (%0d,%0d) got %0b want 1",
               e.x, e.y, rd_valid);
    end
  end

  task automatic tick();
    @(negedge clk);
    wen = 1'b0;
    ren = 1'b0;
    pen = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wr(input int x, input int y, input int i);
    wx   = XW'(x);
    wy   = YW'(y);
    widx = IW'(i);
    wen  = 1'b1;
  endtask

  task automatic rd(input int x, input int y);
    rdx = XW'(x);
    rdy = YW'(y);
    ren = 1'b1;
  endtask

  task automatic pw(input int i, input int c);
    pidx = IW'(i);
    pcol = CB'(c);
    pen  = 1'b1;
  endtask

  task automatic start_clear(input int i);
    clr_index = IW'(i);
    clr = 1'b1;
  endtask

  task automatic check_eq(input string name, input int got,
                          input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drain();
    repeat (5) tick();
  endtask

  initial begin
    repeat (3) tick();
    check_eq("reset rd_index", int'(rd_index), 0);
    check_eq("reset rd_color", int'(rd_color), 0);
    reset = 1'b0;

    for (int i = 0; i < PL; i++) begin
      pw(i, (i == 'h3C) ? 'hABC : int'($urandom_range(4095, 0)));
      tick();
    end
    start_clear(0);
    tick();
    repeat (N + 2) tick();

    wr(5, 7, 'h3C);
    tick();
    tick();
    rd(5, 7);
    tick();
    drain();

    wr(10, 10, 'h22);
    tick();
    wr(10, 10, 'h11);
    rd(10, 10);
    tick();
    rd(10, 10);
    tick();
    drain();

    wr(RX, 0, 'h01);
    tick();
    wr(0, RY, 'h01);
    tick();
    rd(RX, 0);
    tick();
    drain();
    check_eq("drops after out-of-frame writes", int'(drops), 2);

    start_clear('h05);
    tick();
    for (int c = 0; c < N + 2; c++) begin
      if ($urandom_range(99, 0) < 30) begin
        wr($urandom_range(RX - 1, 0), $urandom_range(RY - 1, 0),
           $urandom_range(PL - 1, 0));
      end
      if ($urandom_range(99, 0) < 30) begin
        rd($urandom_range(RX - 1, 0), $urandom_range(RY - 1, 0));
      end
      if ($urandom_range(99, 0) < 5) begin
        pw($urandom_range(PL - 1, 0), $urandom_range(4095, 0));
      end
      tick();
    end
    rd(0, 0);
    tick();
    rd(RX - 1, RY - 1);
    tick();
    rd(RX / 2, RY / 2);
    tick();
    drain();

    start_clear('h07);
    tick();
    for (int c = 1; c < 1000; c++) begin
      if (c % 97 == 0) wr(c % RX, 3, c);
      if (c >= 997) rd(c % RX, 1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("busy after reset", int'(busy), 0);
    check_eq("rd_valid after reset", int'(rd_valid), 0);
    check_eq("drops after reset", int'(drops), 0);
    start_clear('h09);
    tick();
    repeat (N + 2) tick();

    for (int i = 0; i < 8; i++) begin
      wr(3 + i, 4, $urandom_range(PL - 1, 0));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      rd(3 + i, 4);
      tick();
    end
    drain();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99, 0) < 50) begin
        wr($urandom_range(RX + 2, 0), $urandom_range(RY + 1, 0),
           $urandom_range(PL - 1, 0));
      end
      if ($urandom_range(99, 0) < 70) begin
        rd($urandom_range(RX + 2, 0), $urandom_range(RY + 1, 0));
      end
      if ($urandom_range(99, 0) < 20) begin
        pw($urandom_range(PL - 1, 0), $urandom_range(4095, 0));
      end
      if ($urandom_range(1499, 0) == 0) begin
        start_clear($urandom_range(PL - 1, 0));
      end
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
